// File: rtl/switch_debounce_pulse_pkg.sv
// switch_debounce_pkg: shared FSM state type and counter sizing for switch_debounce_pulse
//   db_state_t : debounce FSM states
//   cnt_width  : bits needed to hold the largest of the three cycle counts
package switch_debounce_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_pulse_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, synchronous active-high reset to 0
//   i_clk  clock
//   i_rst  synchronous reset, active-high
//   i_d    asynchronous input
//   o_q    synchronized output (two cycles of latency)
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk)
    if (i_rst) {o_q, meta} <= 2'b00;
    else       {o_q, meta} <= {meta, i_d};

endmodule

// File: rtl/switch_debounce_pulse.sv
// switch_debounce_pulse: debounced button level plus one-cycle press/release pulses
//   i_clk      system clock
//   i_rst      synchronous reset, active-high
//   i_SW1      raw asynchronous button, 1 = pressed
//   o_Switch   debounced level
//   o_Press    one-cycle pulse on accepted press (and auto-repeat pulses)
//   o_Release  one-cycle pulse on accepted release
// Define SWITCH_AUTOREPEAT_EN to make a held button emit periodic o_Press pulses.
module switch_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 12500000,
  parameter int REPEAT_CYCLES   = 2500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_SW1,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release
);

  import switch_debounce_pkg::*;

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic s;
  db_state_t st;
  logic [CW-1:0] cnt, cnt_inc;

  sync_2ff u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_SW1),
    .o_q  (s)
  );

  assign cnt_inc = (cnt == '1) ? cnt : cnt + ONE;

`ifdef SWITCH_AUTOREPEAT_EN
  localparam logic [CW-1:0] HD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] RP = CW'(REPEAT_CYCLES);
  // rep selects the repeat interval once the initial hold period has elapsed
  logic rep;
  always_ff @(posedge i_clk) begin
    o_Press   <= 1'b0;
    o_Release <= 1'b0;
    if (i_rst) begin
      st       <= IDLE;
      cnt      <= '0;
      o_Switch <= 1'b0;
      rep      <= 1'b0;
    end else begin
      case (st)
        IDLE: if (s) begin
          st  <= PRESS_WAIT;
          cnt <= ONE;
        end
        PRESS_WAIT: if (!s) begin
          st  <= IDLE;
          cnt <= '0;
        end else if (cnt == DB) begin
          st       <= PRESSED;
          o_Switch <= 1'b1;
          o_Press  <= 1'b1;
          cnt      <= '0;
          rep      <= 1'b0;
        end else cnt <= cnt_inc;
        PRESSED: if (!s) begin
          st  <= RELEASE_WAIT;
          cnt <= ONE;
        end else if (cnt_inc == (rep ? RP : HD)) begin
          o_Press <= 1'b1;
          cnt     <= '0;
          rep     <= 1'b1;
        end else cnt <= cnt_inc;
        RELEASE_WAIT: if (s) begin
          st  <= PRESSED;
          cnt <= '0;
          rep <= 1'b0;
        end else if (cnt == DB) begin
          st        <= IDLE;
          o_Switch  <= 1'b0;
          o_Release <= 1'b1;
          cnt       <= '0;
        end else cnt <= cnt_inc;
        default: st <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge i_clk) begin
    o_Press   <= 1'b0;
    o_Release <= 1'b0;
    if (i_rst) begin
      st       <= IDLE;
      cnt      <= '0;
      o_Switch <= 1'b0;
    end else begin
      case (st)
        IDLE: if (s) begin
          st  <= PRESS_WAIT;
          cnt <= ONE;
        end
        PRESS_WAIT: if (!s) begin
          st  <= IDLE;
          cnt <= '0;
        end else if (cnt == DB) begin
          st       <= PRESSED;
          o_Switch <= 1'b1;
          o_Press  <= 1'b1;
          cnt      <= '0;
        end else cnt <= cnt_inc;
        PRESSED: if (!s) begin
          st  <= RELEASE_WAIT;
          cnt <= ONE;
        end
        RELEASE_WAIT: if (s) begin
          st  <= PRESSED;
          cnt <= '0;
        end else if (cnt == DB) begin
          st        <= IDLE;
          o_Switch  <= 1'b0;
          o_Release <= 1'b1;
          cnt       <= '0;
        end else cnt <= cnt_inc;
        default: st <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_switch_debounce_pulse.sv
// tb_switch_debounce_pulse: directed scoreboard bench for switch_debounce_pulse
module tb_switch_debounce_pulse;

  logic i_clk = 1'b0;
  logic i_rst, i_SW1;
  logic o_Switch, o_Press, o_Release;
  int pcnt = 0;
  int checks = 0;
  int errs = 0;
  int t0, a;

  typedef struct {int t; logic p; logic r; logic sw;} exp_t;
  exp_t q[$];
  exp_t e;

  switch_debounce_pulse #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_SW1    (i_SW1),
    .o_Switch (o_Switch),
    .o_Press  (o_Press),
    .o_Release(o_Release)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) pcnt <= pcnt + 1;

  task automatic push(input int t, input logic p, input logic r, input logic sw);
    q.push_back('{t, p, r, sw});
  endtask

  task automatic nxt(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  always @(negedge i_clk) begin
    if (q.size() != 0 && q[0].t <= pcnt) begin
      e = q.pop_front();
      checks += 4;
      assert (e.t == pcnt) else begin
        errs++;
        $error("FAIL late_entry: checked at cycle %0d, scheduled for %0d", pcnt, e.t);
      end
      assert (o_Press === e.p) else begin
        errs++;
        $error("FAIL press@%0d: got %b expected %b", pcnt, o_Press, e.p);
      end
      assert (o_Release === e.r) else begin
        errs++;
        $error("FAIL release@%0d: got %b expected %b", pcnt, o_Release, e.r);
      end
      assert (o_Switch === e.sw) else begin
        errs++;
        $error("FAIL switch@%0d: got %b expected %b", pcnt, o_Switch, e.sw);
      end
    end else begin
      checks += 2;
      assert (o_Press === 1'b0) else begin
        errs++;
        $error("FAIL stray_press@%0d: got %b expected 0", pcnt, o_Press);
      end
      assert (o_Release === 1'b0) else begin
        errs++;
        $error("FAIL stray_release@%0d: got %b expected 0", pcnt, o_Release);
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    i_SW1 = 1'b0;
    nxt(2);
    push(pcnt + 1, 1'b0, 1'b0, 1'b0);
    nxt(2);
    i_rst = 1'b0;
    nxt(3);
    t0 = pcnt;
    i_SW1 = 1'b1;
    push(t0 + 6, 1'b0, 1'b0, 1'b0);
    push(t0 + 7, 1'b1, 1'b0, 1'b1);
    push(t0 + 8, 1'b0, 1'b0, 1'b1);
    nxt(10);
    t0 = pcnt;
    i_SW1 = 1'b0;
    push(t0 + 6, 1'b0, 1'b0, 1'b1);
    push(t0 + 7, 1'b0, 1'b1, 1'b0);
    push(t0 + 8, 1'b0, 1'b0, 1'b0);
    nxt(10);
    t0 = pcnt;
    i_SW1 = 1'b1;
    nxt(3);
    i_SW1 = 1'b0;
    push(t0 + 12, 1'b0, 1'b0, 1'b0);
    nxt(14);
    i_SW1 = 1'b1;
    nxt(2);
    i_SW1 = 1'b0;
    nxt(2);
    i_SW1 = 1'b1;
    nxt(2);
    i_SW1 = 1'b0;
    nxt(2);
    t0 = pcnt;
    i_SW1 = 1'b1;
    push(t0 + 7, 1'b1, 1'b0, 1'b1);
    nxt(10);
    t0 = pcnt;
    i_SW1 = 1'b0;
    nxt(2);
    i_SW1 = 1'b1;
    nxt(2);
    i_SW1 = 1'b0;
    push(t0 + 6, 1'b0, 1'b0, 1'b1);
    push(t0 + 11, 1'b0, 1'b1, 1'b0);
    nxt(14);
    i_SW1 = 1'b1;
    nxt(3);
    i_rst = 1'b1;
    nxt(1);
    i_rst = 1'b0;
    t0 = pcnt;
    a = t0 + 7;
    push(t0 + 1, 1'b0, 1'b0, 1'b0);
    push(a, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
`ifdef SWITCH_AUTOREPEAT_EN
      push(a + 20 + 8 * k, 1'b1, 1'b0, 1'b1);
`else
      if (k == 1) push(a + 30, 1'b0, 1'b0, 1'b1);
`endif
    end
    nxt(67);
    i_SW1 = 1'b0;
    push(pcnt + 7, 1'b0, 1'b1, 1'b0);
    nxt(10);
    t0 = pcnt;
    i_SW1 = 1'b1;
    push(t0 + 7, 1'b1, 1'b0, 1'b1);
    nxt(10);
    i_rst = 1'b1;
    nxt(1);
    i_rst = 1'b0;
    t0 = pcnt;
    push(t0 + 1, 1'b0, 1'b0, 1'b0);
    push(t0 + 7, 1'b1, 1'b0, 1'b1);
    nxt(10);
    t0 = pcnt;
    i_SW1 = 1'b0;
    push(t0 + 7, 1'b0, 1'b1, 1'b0);
    nxt(12);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
